cache_reader_8_16: RTL
======================

Name: cache_reader_8_16

Overview:
- Read-side companion to the 8-entry x 16-bit cache register file.
- Takes the file's flat memory-state bus and serves read requests over a valid/ready request channel.
- Returns data over a valid/ready response channel, one beat per cycle.
- Supports single reads and wrapping burst reads.
- Sits between the register file and any consumer, such as the ALU operand fetch or a debug dump.

Parameters:
- N_ENTRIES, 8, number of cache entries. Fixed at 8 for this revision.
- WIDTH, 16, bits per entry.
- BURST_LEN, 8, beats per burst, range 1..N_ENTRIES.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- memory_state  in  128  flat register-file contents; entry i occupies bits [16i+15:16i]
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at a clk edge
- req_addr  in  3  first entry to read
- req_burst  in  1  0 = single beat, 1 = BURST_LEN beats
- rsp_valid  out  1  response beat present
- rsp_ready  in  1  consumer takes the beat when rsp_valid && rsp_ready
- rsp_data  out  16  entry contents
- rsp_addr  out  3  entry index of this beat
- rsp_last  out  1  final beat of the request (always 1 for a single read)
- busy  out  1  high while state != IDLE or rsp_valid

Behaviour:
- Reset (async, rst=1): state=IDLE, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_last=0, internal ptr/count=0. Outputs take these values immediately on rst assertion, with no clock needed.
- Output stage is a single register slot. The slot is "free" when !rsp_valid || rsp_ready.
- req_ready = (state==IDLE) && slot free. It is combinational from rsp_ready.
- States: IDLE, STREAM.
- IDLE, on accept:
  - Load the slot with entry req_addr, sampled from memory_state at that edge.
  - Set rsp_addr=req_addr.
  - Single read, or burst with BURST_LEN=1: rsp_last=1, stay in IDLE.
  - Otherwise: rsp_last=0, ptr=req_addr+1 (mod 8), count=BURST_LEN-2, go to STREAM.
- Latency: rsp_valid rises on the clk edge that accepts the request (one cycle request-to-response).
- STREAM, each edge with slot free:
  - Load entry ptr; ptr = ptr+1 mod 8.
  - If count==0: rsp_last=1, go to IDLE. Else count = count-1.
- STREAM with slot not free: hold slot, ptr and count. No beat is dropped or duplicated.
- Wrap-around: addresses increment 7 -> 0 and never saturate.
- Data is captured at load time. Later changes to memory_state do not alter a beat already held in the slot.
- Slot empties when consumed and nothing is loaded that edge: rsp_valid=0, rsp_last=0.
- Simultaneous consume and new accept in IDLE: the slot is reloaded the same edge, allowing back-to-back singles at one per cycle.
- Requests are not accepted in STREAM (req_ready=0). A new request is accepted on the edge after the last beat is consumed, or on the same edge if the last beat is consumed in IDLE.
- rst mid-burst: burst abandoned, no rsp_last issued, state returns to IDLE.
- req_addr and req_burst are sampled only on accept.

Optional Feature:
- Macro: CACHE_READER_SNOOP_EN.
- Defined:
  - Adds inputs wr_sel (8, one-hot decoded write selector) and wr_data (16).
  - When a beat is loaded from entry e and wr_sel[e]=1 on that edge, the slot takes wr_data instead of memory_state. This forwards the in-flight write.
  - More than one bit set in wr_sel: forward if the loaded entry's bit is set.
- Undefined: ports absent, always reads memory_state.

Decomposition:
- Shared package cache_pkg:
  - Constants: N_ENTRIES=8, WIDTH=16, ADDR_W=3.
  - Typedefs: word_t (logic[15:0]), addr_t (logic[2:0]), rd_state_t enum {IDLE, STREAM}.
  - Also used by the writer side.
- One sub-module: cache_rd_mux_8_16, a combinational 8:1 x 16-bit entry select (memory_state, addr -> word). It is instantiated once.

Test Plan:
- Entries preloaded i*0x11 (entry 3 = 0x0033). Single read addr=3, rsp_ready=1 -> one beat: data=0x0033, addr=3, last=1, one cycle after accept. req_ready high again the same cycle.
- Burst addr=5, BURST_LEN=8, rsp_ready=1 -> beats at addr 5,6,7,0,1,2,3,4 with data 0x0055..0x0044 (wrapped). Consecutive cycles. last=1 only on addr 4.
- Burst addr=0 with rsp_ready toggling 1,0,0,1,... -> all 8 beats in order. The beat held during rsp_ready=0 stays stable in data and addr. No duplicates or drops.
- Four back-to-back singles (addr 7,0,2,1), req_valid held, rsp_ready=1 -> four responses on four consecutive cycles, each last=1.
- rst asserted mid-burst after the 3rd beat -> rsp_valid=0 and busy=0 immediately. A new single to addr=6 after release returns 0x0066, last=1.
- With CACHE_READER_SNOOP_EN: single to addr=2 while wr_sel=0x04 and wr_data=0xBEEF on the accept edge -> rsp_data=0xBEEF. The same test with wr_sel=0x08 -> rsp_data=0x0022.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg
// Shared types and constants for the 8-entry x 16-bit cache register file
// and its reader/writer companions.
//   N_ENTRIES  : number of cache entries
//   WIDTH      : bits per entry
//   ADDR_W     : entry index width
//   word_t     : one cache entry
//   addr_t     : entry index
//   rd_state_t : reader control states
package cache_pkg;

  localparam int N_ENTRIES = 8;
  localparam int WIDTH     = 16;
  localparam int ADDR_W    = 3;

  typedef logic [WIDTH-1:0]  word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic {
    IDLE,
    STREAM
  } rd_state_t;

endpackage

// File: rtl/cache_rd_mux_8_16.sv
// cache_rd_mux_8_16
// Combinational 8:1 x 16-bit entry select from the flat register-file bus.
// Ports:
//   memory_state_i : flat contents, entry i at bits [16i+15:16i]
//   addr_i         : entry to select
//   word_o         : selected entry
module cache_rd_mux_8_16
  import cache_pkg::*;
(
  input  logic [N_ENTRIES*WIDTH-1:0] memory_state_i,
  input  addr_t                      addr_i,
  output word_t                      word_o
);

  // Each entry is 16 bits wide, so the entry index shifted left by four
  // is the exact bit offset of that entry inside the flat bus.
  always_comb begin
    word_o = memory_state_i[{addr_i, 4'b0000} +: WIDTH];
  end

endmodule

// File: rtl/cache_reader_8_16.sv
// cache_reader_8_16
// Read-side companion to the 8 x 16 cache register file. Serves single and
// wrapping burst reads over a valid/ready request channel and returns one
// beat per cycle over a valid/ready response channel.
// Optional feature macro: CACHE_READER_SNOOP_EN (adds wr_sel/wr_data and
// forwards an in-flight write into the beat being loaded).
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   memory_state          : flat register-file contents
//   req_valid/req_ready   : request handshake
//   req_addr, req_burst   : first entry, single(0)/burst(1)
//   rsp_valid/rsp_ready   : response handshake
//   rsp_data, rsp_addr    : beat contents and its entry index
//   rsp_last              : final beat of the request
//   busy                  : streaming or holding a beat
//   wr_sel, wr_data       : (snoop build only) write being applied this edge
module cache_reader_8_16
  import cache_pkg::*;
#(
  parameter int BURST_LEN = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_ENTRIES*WIDTH-1:0] memory_state,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  addr_t                      req_addr,
  input  logic                       req_burst,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output word_t                      rsp_data,
  output addr_t                      rsp_addr,
  output logic                       rsp_last,
`ifdef CACHE_READER_SNOOP_EN
  input  logic [N_ENTRIES-1:0]       wr_sel,
  input  word_t                      wr_data,
`endif
  output logic                       busy
);

  // Beats remaining after the second one; the first two beats are loaded
  // on the accept edge and the first STREAM edge respectively.
  localparam logic [2:0] COUNT_INIT = (BURST_LEN >= 2) ? 3'(BURST_LEN - 2) : 3'd0;

  rd_state_t  state_q, state_d;
  addr_t      ptr_q, ptr_d;
  logic [2:0] count_q, count_d;
  logic       rspValid_q, rspValid_d;
  word_t      rspData_q, rspData_d;
  addr_t      rspAddr_q, rspAddr_d;
  logic       rspLast_q, rspLast_d;

  logic       slotFree;
  logic       accept;
  addr_t      muxAddr;
  word_t      muxWord;
  word_t      loadWord;

  // The single output slot can take a new beat when it is empty or its
  // current beat is being consumed on this edge.
  assign slotFree  = !rspValid_q || rsp_ready;
  assign req_ready = (state_q == IDLE) && slotFree;
  assign accept    = req_valid && req_ready;

  // In IDLE the only possible load is the first beat of a new request, so
  // the mux follows req_addr; while streaming it follows the burst pointer.
  assign muxAddr = (state_q == STREAM) ? ptr_q : req_addr;

  cache_rd_mux_8_16 u_mux (
    .memory_state_i (memory_state),
    .addr_i         (muxAddr),
    .word_o         (muxWord)
  );

`ifdef CACHE_READER_SNOOP_EN
  // A write landing on the same entry this edge would not yet be visible on
  // memory_state, so take the write data directly.
  assign loadWord = wr_sel[muxAddr] ? wr_data : muxWord;
`else
  assign loadWord = muxWord;
`endif

  // Next-state and slot-load logic. Everything holds by default; a load
  // only happens with a free slot, which is what keeps beats from being
  // dropped or duplicated under backpressure.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    rspValid_d = rspValid_q;
    rspData_d  = rspData_q;
    rspAddr_d  = rspAddr_q;
    rspLast_d  = rspLast_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rspValid_d = 1'b1;
          rspData_d  = loadWord;
          rspAddr_d  = req_addr;
          if (!req_burst || BURST_LEN == 1) begin
            rspLast_d = 1'b1;
          end else begin
            rspLast_d = 1'b0;
            ptr_d     = addr_t'(req_addr + 3'd1);
            count_d   = COUNT_INIT;
            state_d   = STREAM;
          end
        end else if (slotFree) begin
          rspValid_d = 1'b0;
          rspLast_d  = 1'b0;
        end
      end

      STREAM: begin
        if (slotFree) begin
          rspValid_d = 1'b1;
          rspData_d  = loadWord;
          rspAddr_d  = ptr_q;
          ptr_d      = addr_t'(ptr_q + 3'd1);
          if (count_q == 3'd0) begin
            rspLast_d = 1'b1;
            state_d   = IDLE;
          end else begin
            rspLast_d = 1'b0;
            count_d   = count_q - 3'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output slot registers. Reset abandons any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      count_q    <= '0;
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
      rspAddr_q  <= '0;
      rspLast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
      rspAddr_q  <= rspAddr_d;
      rspLast_q  <= rspLast_d;
    end
  end

  assign rsp_valid = rspValid_q;
  assign rsp_data  = rspData_q;
  assign rsp_addr  = rspAddr_q;
  assign rsp_last  = rspLast_q;
  assign busy      = (state_q != IDLE) || rspValid_q;

endmodule
